// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and constants for the SRAM port arbiter: FSM encoding and the
// downstream write-flag derivation.
package sram_port_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        I_ADDR = 3'd1,
        I_DATA = 3'd2,
        D_ADDR = 3'd3,
        D_DATA = 3'd4
    } arbState_t;

    localparam logic MEM_WR_READ = 1'b0;
    localparam logic [3:0] WEN_NONE = 4'b0000;

    // Any byte enable set makes the downstream access a write.
    function automatic logic memWrOf(input logic [3:0] wen);
        return |wen;
    endfunction

endpackage

// File: rtl/sram_port_arbiter.sv
// Arbitrates one single-outstanding SRAM-like port between fetch and data
// sides; data wins, and cancelled fetch responses are swallowed.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_cancel,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_data_ok,
    input  logic              data_req,
    input  logic [3:0]        data_wen,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_data_ok,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [3:0]        mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata
);

    arbState_t state, nextState;
    logic      drop, nextDrop;
    logic      grantInst, grantData;
    logic      instDone, dataDone;

    always_comb begin
        nextState = state;
        nextDrop  = drop;
        grantInst = 1'b0;
        grantData = 1'b0;
        instDone  = 1'b0;
        dataDone  = 1'b0;
        case (state)
            IDLE: begin
                if (data_req) begin
                    nextState = D_ADDR;
                    grantData = 1'b1;
                end else if (inst_req) begin
                    nextState = I_ADDR;
                    grantInst = 1'b1;
                end
            end
            I_ADDR: begin
                if (mem_addr_ok) begin
                    if (mem_data_ok) begin
                        nextState = IDLE;
                        instDone  = 1'b1;
                    end else begin
                        nextState = I_DATA;
                    end
                end
            end
            I_DATA: begin
                if (mem_data_ok) begin
                    nextState = IDLE;
                    instDone  = 1'b1;
                end
            end
            D_ADDR: begin
                if (mem_addr_ok) begin
                    if (mem_data_ok) begin
                        nextState = IDLE;
                        dataDone  = 1'b1;
                    end else begin
                        nextState = D_DATA;
                    end
                end
            end
            D_DATA: begin
                if (mem_data_ok) begin
                    nextState = IDLE;
                    dataDone  = 1'b1;
                end
            end
            default: nextState = IDLE;
        endcase

        // A cancel only matters while a fetch owns the port; the flag lives
        // until the transaction drains back to IDLE.
        if ((state == I_ADDR || state == I_DATA) && inst_cancel)
            nextDrop = 1'b1;
        if (nextState == IDLE)
            nextDrop = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            drop      <= 1'b0;
            mem_wr    <= MEM_WR_READ;
            mem_wen   <= WEN_NONE;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state <= nextState;
            drop  <= nextDrop;
            if (grantData) begin
                mem_wr    <= memWrOf(data_wen);
                mem_wen   <= data_wen;
                mem_addr  <= data_addr;
                mem_wdata <= data_wdata;
            end else if (grantInst) begin
                mem_wr    <= MEM_WR_READ;
                mem_wen   <= WEN_NONE;
                mem_addr  <= inst_addr;
                mem_wdata <= '0;
            end
        end
    end

    assign mem_req = (state == I_ADDR) || (state == D_ADDR);

    // Completion is a combinational pass-through of the downstream handshake;
    // a cancel arriving with the response suppresses it as well.
    assign inst_data_ok = instDone & ~drop & ~inst_cancel & ~rst;
    assign data_data_ok = dataDone & ~rst;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized requesters/slave checked every cycle against a transaction model.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_cancel, inst_data_ok;
    logic [31:0] inst_addr, inst_rdata;
    logic        data_req, data_data_ok;
    logic [3:0]  data_wen;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_cancel(inst_cancel),
        .inst_rdata(inst_rdata), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .data_data_ok(data_data_ok),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata)
    );

    // Transaction-level model: one outstanding access, described by who owns
    // it, whether its address was accepted, and whether it was cancelled.
    bit          mBusy, mIsData, mAccepted, mDropped;
    logic        mWr;
    logic [3:0]  mWen;
    logic [31:0] mAddr, mWdata;
    bit          sawInstOk, sawDataOk;
    logic        expComplete, expInstOk, expDataOk, expMemReq;

    assign expComplete = !rst && mBusy &&
                         (mAccepted ? mem_data_ok : (mem_addr_ok && mem_data_ok));
    assign expInstOk   = expComplete && !mIsData && !mDropped && !inst_cancel;
    assign expDataOk   = expComplete && mIsData;
    assign expMemReq   = mBusy && !mAccepted;

    always @(posedge clk) begin
        sawInstOk = expInstOk;
        sawDataOk = expDataOk;
        if (rst) begin
            mBusy = 0; mIsData = 0; mAccepted = 0; mDropped = 0;
            mWr = 0; mWen = 0; mAddr = 0; mWdata = 0;
        end else if (!mBusy) begin
            if (data_req) begin
                mBusy = 1; mIsData = 1; mAccepted = 0; mDropped = 0;
                mWr = |data_wen; mWen = data_wen; mAddr = data_addr; mWdata = data_wdata;
            end else if (inst_req) begin
                mBusy = 1; mIsData = 0; mAccepted = 0; mDropped = 0;
                mWr = 0; mWen = 0; mAddr = inst_addr; mWdata = 0;
            end
        end else if (expComplete) begin
            mBusy = 0; mDropped = 0; mAccepted = 0;
        end else begin
            if (!mAccepted && mem_addr_ok) mAccepted = 1;
            if (!mIsData && inst_cancel) mDropped = 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("mem_req", 32'(mem_req), 32'(expMemReq));
        chk("mem_wr", 32'(mem_wr), 32'(mWr));
        chk("mem_wen", 32'(mem_wen), 32'(mWen));
        chk("mem_addr", mem_addr, mAddr);
        chk("mem_wdata", mem_wdata, mWdata);
        chk("inst_data_ok", 32'(inst_data_ok), 32'(expInstOk));
        chk("data_data_ok", 32'(data_data_ok), 32'(expDataOk));
        if (expInstOk) chk("inst_rdata", inst_rdata, mem_rdata);
        if (expDataOk) chk("data_rdata", data_rdata, mem_rdata);
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idleSlave();
        mem_addr_ok = 0; mem_data_ok = 0;
    endtask

    initial begin
        rst = 1; inst_req = 0; inst_addr = 0; inst_cancel = 0;
        data_req = 0; data_wen = 0; data_addr = 0; data_wdata = 0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
        cyc(); cyc();
        #1;
        chk("rst mem_req", 32'(mem_req), 32'h0);
        chk("rst mem_addr", mem_addr, 32'h0);
        chk("rst mem_wen", 32'(mem_wen), 32'h0);
        rst = 0;

        // Fetch only
        cyc(); inst_req = 1; inst_addr = 32'hBFC00000; #1;
        chk("f0 mem_req", 32'(mem_req), 32'h0);
        cyc(); mem_addr_ok = 1; #1;
        chk("f1 mem_req", 32'(mem_req), 32'h1);
        chk("f1 mem_addr", mem_addr, 32'hBFC00000);
        chk("f1 mem_wr", 32'(mem_wr), 32'h0);
        cyc(); idleSlave(); #1;
        chk("f2 mem_req", 32'(mem_req), 32'h0);
        cyc(); mem_data_ok = 1; mem_rdata = 32'h24010001; #1;
        chk("f3 inst_ok", 32'(inst_data_ok), 32'h1);
        chk("f3 inst_rdata", inst_rdata, 32'h24010001);
        cyc(); idleSlave(); inst_req = 0; #1;
        chk("f4 inst_ok", 32'(inst_data_ok), 32'h0);

        // Contention: data read wins, fetch follows after one idle cycle
        cyc(); inst_req = 1; inst_addr = 32'hBFC00004;
        data_req = 1; data_wen = 4'b0000; data_addr = 32'h80000010; data_wdata = 32'h0;
        cyc(); mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'h11112222; #1;
        chk("c1 mem_addr", mem_addr, 32'h80000010);
        chk("c1 mem_wr", 32'(mem_wr), 32'h0);
        chk("c1 data_ok", 32'(data_data_ok), 32'h1);
        chk("c1 data_rdata", data_rdata, 32'h11112222);
        chk("c1 inst_ok", 32'(inst_data_ok), 32'h0);
        cyc(); idleSlave(); data_req = 0; #1;
        chk("c2 idle mem_req", 32'(mem_req), 32'h0);
        // Fast slave on the follow-up fetch
        cyc(); mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'h03E00008; #1;
        chk("c3 mem_req", 32'(mem_req), 32'h1);
        chk("c3 mem_addr", mem_addr, 32'hBFC00004);
        chk("c3 inst_ok", 32'(inst_data_ok), 32'h1);
        cyc(); idleSlave(); inst_req = 0; #1;
        chk("c4 mem_req", 32'(mem_req), 32'h0);

        // Store
        cyc(); data_req = 1; data_wen = 4'b0011; data_addr = 32'h80000002; data_wdata = 32'h0000BEEF;
        cyc(); mem_addr_ok = 1; #1;
        chk("s1 mem_wr", 32'(mem_wr), 32'h1);
        chk("s1 mem_wen", 32'(mem_wen), 32'h3);
        chk("s1 mem_wdata", mem_wdata, 32'h0000BEEF);
        chk("s1 data_ok", 32'(data_data_ok), 32'h0);
        cyc(); mem_addr_ok = 0; mem_data_ok = 1; #1;
        chk("s2 data_ok", 32'(data_data_ok), 32'h1);
        cyc(); idleSlave(); data_req = 0; data_wen = 0;

        // Cancel during I_DATA
        cyc(); inst_req = 1; inst_addr = 32'hBFC00010;
        cyc(); mem_addr_ok = 1;
        cyc(); idleSlave(); inst_cancel = 1; inst_req = 0;
        cyc(); inst_cancel = 0; mem_data_ok = 1; mem_rdata = 32'hDEADBEEF; #1;
        chk("x1 inst_ok", 32'(inst_data_ok), 32'h0);
        cyc(); idleSlave(); inst_req = 1; inst_addr = 32'hBFC00380;
        cyc(); mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'h42000018; #1;
        chk("x2 mem_addr", mem_addr, 32'hBFC00380);
        chk("x2 inst_ok", 32'(inst_data_ok), 32'h1);
        cyc(); idleSlave(); inst_req = 0;

        // Reset in D_DATA, late response ignored
        cyc(); data_req = 1; data_wen = 0; data_addr = 32'h80000040;
        cyc(); mem_addr_ok = 1;
        cyc(); idleSlave(); rst = 1;
        cyc(); rst = 0; data_req = 0; mem_data_ok = 1; #1;
        chk("r1 mem_req", 32'(mem_req), 32'h0);
        chk("r1 mem_addr", mem_addr, 32'h0);
        chk("r1 data_ok", 32'(data_data_ok), 32'h0);
        chk("r1 inst_ok", 32'(inst_data_ok), 32'h0);
        cyc(); idleSlave();

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            cyc();
            rst = ($urandom_range(0, 299) == 0);
            if (inst_req && (sawInstOk || inst_cancel)) inst_req = 0;
            inst_cancel = 0;
            if (data_req && sawDataOk) data_req = 0;
            if (rst) begin
                inst_req = 0; data_req = 0;
            end else begin
                if (inst_req && $urandom_range(0, 11) == 0) inst_cancel = 1;
                else if (!inst_req && $urandom_range(0, 19) == 0) inst_cancel = 1;
                if (!inst_req && !inst_cancel && $urandom_range(0, 2) == 0) begin
                    inst_req = 1; inst_addr = $urandom & 32'hFFFFFFFC;
                end
                if (!data_req && $urandom_range(0, 3) == 0) begin
                    data_req = 1;
                    data_wen = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
                    data_addr = $urandom; data_wdata = $urandom;
                end
            end
            mem_addr_ok = ($urandom_range(0, 1) == 1);
            mem_data_ok = ($urandom_range(0, 2) == 0);
            mem_rdata = $urandom;
        end

        cyc(); idleSlave(); inst_req = 0; data_req = 0; inst_cancel = 0;
        cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
